// File: rtl/load_store_unit.sv
// RV32I memory-stage load/store unit: one access at a time through a
// four-state request/wait handshake with the data-memory access unit.
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ls_valid,
    input  logic        ls_is_store,
    input  logic [2:0]  ls_funct3,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [4:0]  ls_rd,
    output logic        ls_stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misalign_exc,
    output logic        fault_exc,
    output logic [31:0] exc_addr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        mem_req,
    output logic        mem_wr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    input  logic        mem_error
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b100, 3'b101:         ok = ~is_store;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] a);
        logic ok;
        case (f3[1:0])
            2'b00:   ok = 1'b1;
            2'b01:   ok = (a[0] == 1'b0);
            2'b10:   ok = (a == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] s;
        case (f3[1:0])
            2'b00:   s = 4'b0001 << a;
            2'b01:   s = 4'b0011 << {a[1], 1'b0};
            2'b10:   s = 4'b1111;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        case (f3[1:0])
            2'b00:   r = {4{d[7:0]}};
            2'b01:   r = {2{d[15:0]}};
            2'b10:   r = d;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Byte lanes are shifted down to bit 0 before sign/zero extension.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] d);
        logic [31:0] sh;
        logic [31:0] r;
        sh = d >> {a, 3'b000};
        case (f3)
            3'b000:  r = {{24{sh[7]}}, sh[7:0]};
            3'b001:  r = {{16{sh[15]}}, sh[15:0]};
            3'b100:  r = {24'h00_0000, sh[7:0]};
            3'b101:  r = {16'h0000, sh[15:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

    logic [1:0]  state_q,        state_d;
    logic [31:0] addr_q,         addr_d;
    logic [2:0]  funct3_q,       funct3_d;
    logic        is_store_q,     is_store_d;
    logic [31:0] wdata_q,        wdata_d;
    logic [4:0]  rd_q,           rd_d;
    logic        wb_valid_q,     wb_valid_d;
    logic [4:0]  wb_rd_q,        wb_rd_d;
    logic [31:0] wb_data_q,      wb_data_d;
    logic        misalign_q,     misalign_d;
    logic        fault_q,        fault_d;
    logic [31:0] exc_addr_q,     exc_addr_d;
    logic        req_legal_s;
    logic        req_aligned_s;
    logic        bus_phase_s;

    assign req_legal_s   = f3_legal(ls_is_store, ls_funct3);
    assign req_aligned_s = f3_aligned(ls_funct3, ls_addr[1:0]);
    assign bus_phase_s   = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

    // Next-state, request latch and registered response outputs.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        funct3_d   = funct3_q;
        is_store_d = is_store_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        misalign_d = 1'b0;
        fault_d    = 1'b0;
        exc_addr_d = 32'h0000_0000;
        case (state_q)
            ST_IDLE: begin
                if (ls_valid) begin
                    addr_d     = ls_addr;
                    funct3_d   = ls_funct3;
                    is_store_d = ls_is_store;
                    wdata_d    = ls_wdata;
                    rd_d       = ls_rd;
                    if (req_legal_s && req_aligned_s) begin
                        state_d = ST_ISSUE;
                    end else begin
                        state_d    = ST_RESP;
                        misalign_d = req_legal_s;
                        fault_d    = ~req_legal_s;
                        exc_addr_d = ls_addr;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (mem_ready) begin
                    state_d = ST_RESP;
                    if (mem_error) begin
                        fault_d    = 1'b1;
                        exc_addr_d = addr_q;
                    end else if (!is_store_q) begin
                        wb_data_d = load_extend(funct3_q, addr_q[1:0], mem_rdata);
                        if (rd_q != 5'd0) begin
                            wb_valid_d = 1'b1;
                            wb_rd_d    = rd_q;
                        end else begin
                            wb_valid_d = 1'b0;
                        end
                    end else begin
                        wb_valid_d = 1'b0;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, latched request and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= 32'h0000_0000;
            funct3_q   <= 3'b000;
            is_store_q <= 1'b0;
            wdata_q    <= 32'h0000_0000;
            rd_q       <= 5'd0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'h0000_0000;
            misalign_q <= 1'b0;
            fault_q    <= 1'b0;
            exc_addr_q <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            funct3_q   <= funct3_d;
            is_store_q <= is_store_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            misalign_q <= misalign_d;
            fault_q    <= fault_d;
            exc_addr_q <= exc_addr_d;
        end
    end

    // Bus signals decode straight from the state and latch flops, so they are zero outside ISSUE/WAIT.
    always_comb begin
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = 32'h0000_0000;
        mem_wdata = 32'h0000_0000;
        mem_wstrb = 4'b0000;
        if (bus_phase_s) begin
            mem_req  = (state_q == ST_ISSUE);
            mem_wr   = is_store_q;
            mem_addr = {addr_q[31:2], 2'b00};
            if (is_store_q) begin
                mem_wdata = store_lanes(funct3_q, wdata_q);
                mem_wstrb = store_strobe(funct3_q, addr_q[1:0]);
            end else begin
                mem_wdata = 32'h0000_0000;
                mem_wstrb = 4'b0000;
            end
        end else begin
            mem_req = 1'b0;
        end
    end

    assign ls_stall     = ls_valid && (state_q != ST_RESP);
    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign misalign_exc = misalign_q;
    assign fault_exc    = fault_q;
    assign exc_addr     = exc_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses push expected bus
// and response records; a negedge monitor pops and compares them.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ls_valid, ls_is_store;
    logic [2:0]  ls_funct3;
    logic [31:0] ls_addr, ls_wdata;
    logic [4:0]  ls_rd;
    logic        ls_stall, wb_valid, misalign_exc, fault_exc, mem_req, mem_wr;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, exc_addr, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready, mem_error;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n), .ls_valid(ls_valid), .ls_is_store(ls_is_store),
        .ls_funct3(ls_funct3), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_rd(ls_rd),
        .ls_stall(ls_stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .misalign_exc(misalign_exc), .fault_exc(fault_exc), .exc_addr(exc_addr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wr;
    } bus_t;

    typedef struct {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        mis;
        logic        fault;
        logic [31:0] eaddr;
        logic        bus;
    } resp_t;

    bus_t  exp_bus[$];
    resp_t exp_resp[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    ready_cyc = -100;
    int    req_count = 0;
    int    r_delay = 1;
    logic [31:0] r_rdata = 32'h0;
    logic  r_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bus_t mk_bus(input logic [31:0] a, input logic [31:0] d,
                                    input logic [3:0] s, input logic w);
        bus_t b;
        b.addr = a; b.wdata = d; b.wstrb = s; b.wr = w;
        return b;
    endfunction

    function automatic resp_t mk_resp(input logic v, input logic [4:0] rd, input logic [31:0] d,
                                      input logic m, input logic f, input logic [31:0] ea,
                                      input logic bus);
        resp_t r;
        r.valid = v; r.rd = rd; r.data = d; r.mis = m; r.fault = f; r.eaddr = ea; r.bus = bus;
        return r;
    endfunction

    // Memory responder: answers each request after r_delay cycles.
    initial begin
        mem_ready = 1'b0; mem_error = 1'b0; mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                repeat (r_delay) @(posedge clk);
                #1;
                mem_ready = 1'b1; mem_error = r_err; mem_rdata = r_rdata;
                @(posedge clk);
                #1;
                mem_ready = 1'b0; mem_error = 1'b0; mem_rdata = 32'h0;
            end
        end
    end

    // Monitor: bus requests and response cycles are checked against the queues.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (mem_ready === 1'b1) ready_cyc = cyc;
            if (mem_req === 1'b1) begin
                bus_t b;
                req_count++;
                if (exp_bus.size() == 0) begin
                    chk("unexpected_req", {31'h0, mem_req}, 32'h0);
                end else begin
                    b = exp_bus.pop_front();
                    chk("mem_addr", mem_addr, b.addr);
                    chk("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, b.wstrb});
                    chk("mem_wr", {31'h0, mem_wr}, {31'h0, b.wr});
                    if (b.wr) chk("mem_wdata", mem_wdata, b.wdata);
                end
            end
            if (ls_valid === 1'b1 && ls_stall === 1'b0) begin
                resp_t r;
                if (exp_resp.size() == 0) begin
                    chk("unexpected_resp", {31'h0, ls_stall}, 32'h1);
                end else begin
                    r = exp_resp.pop_front();
                    chk("wb_valid", {31'h0, wb_valid}, {31'h0, r.valid});
                    chk("misalign_exc", {31'h0, misalign_exc}, {31'h0, r.mis});
                    chk("fault_exc", {31'h0, fault_exc}, {31'h0, r.fault});
                    if (r.valid) begin
                        chk("wb_data", wb_data, r.data);
                        chk("wb_rd", {27'h0, wb_rd}, {27'h0, r.rd});
                    end
                    if (r.mis || r.fault) chk("exc_addr", exc_addr, r.eaddr);
                    if (r.bus) chk("resp_latency", cyc, ready_cyc + 1);
                end
            end else begin
                chk("idle_outs", {exc_addr[30:0], wb_valid | misalign_exc | fault_exc}, 32'h0);
            end
        end
    end

    task automatic do_tx(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd, input int dly,
                         input logic [31:0] rdat, input logic err, input logic has_bus,
                         input bus_t eb, input resp_t er);
        int n;
        int r0;
        r_delay = dly; r_rdata = rdat; r_err = err;
        if (has_bus) exp_bus.push_back(eb);
        exp_resp.push_back(er);
        r0 = req_count;
        @(posedge clk);
        #1;
        ls_is_store = st; ls_funct3 = f3; ls_addr = a; ls_wdata = wd; ls_rd = rd; ls_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        if (has_bus) chk("lat_req", {31'h0, mem_req}, 32'h1);
        else         chk("lat_exc_stall", {31'h0, ls_stall}, 32'h0);
        n = 0;
        while (ls_stall !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("timeout", 32'h1, 32'h0);
        @(posedge clk);
        #1;
        ls_valid = 1'b0;
        repeat (2) @(posedge clk);
        chk("req_count", req_count - r0, has_bus ? 32'd1 : 32'd0);
    endtask

    initial begin
        int r0;
        logic wv;
        rst_n = 1'b0; ls_valid = 1'b0; ls_is_store = 1'b0; ls_funct3 = 3'b000;
        ls_addr = 32'h0; ls_wdata = 32'h0; ls_rd = 5'd0;
        #12;
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_misc", {26'h0, wb_valid, misalign_exc, fault_exc, mem_req, mem_wr, ls_stall}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        do_tx(1'b0, 3'b000, 32'h0000_1003, 32'h0, 5'd5, 2, 32'h80FF_FFFF, 1'b0, 1'b1,
              mk_bus(32'h0000_1000, 32'h0, 4'b0000, 1'b0),
              mk_resp(1'b1, 5'd5, 32'hFFFF_FF80, 1'b0, 1'b0, 32'h0, 1'b1));
        do_tx(1'b0, 3'b101, 32'h0000_2002, 32'h0, 5'd7, 1, 32'hBEEF_1234, 1'b0, 1'b1,
              mk_bus(32'h0000_2000, 32'h0, 4'b0000, 1'b0),
              mk_resp(1'b1, 5'd7, 32'h0000_BEEF, 1'b0, 1'b0, 32'h0, 1'b1));
        do_tx(1'b1, 3'b001, 32'h0000_2002, 32'h0000_A5C3, 5'd0, 3, 32'h0, 1'b0, 1'b1,
              mk_bus(32'h0000_2000, 32'hA5C3_A5C3, 4'b1100, 1'b1),
              mk_resp(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1));
        do_tx(1'b0, 3'b010, 32'h0000_3001, 32'h0, 5'd4, 1, 32'h0, 1'b0, 1'b0,
              mk_bus(32'h0, 32'h0, 4'b0000, 1'b0),
              mk_resp(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h0000_3001, 1'b0));
        do_tx(1'b1, 3'b010, 32'h0000_4000, 32'h1234_5678, 5'd0, 2, 32'h0, 1'b1, 1'b1,
              mk_bus(32'h0000_4000, 32'h1234_5678, 4'b1111, 1'b1),
              mk_resp(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h0000_4000, 1'b1));
        do_tx(1'b0, 3'b000, 32'h0000_1001, 32'h0, 5'd2, 1, 32'h80FF_7F00, 1'b0, 1'b1,
              mk_bus(32'h0000_1000, 32'h0, 4'b0000, 1'b0),
              mk_resp(1'b1, 5'd2, 32'h0000_007F, 1'b0, 1'b0, 32'h0, 1'b1));
        do_tx(1'b0, 3'b001, 32'h0000_1002, 32'h0, 5'd31, 1, 32'h8001_0000, 1'b0, 1'b1,
              mk_bus(32'h0000_1000, 32'h0, 4'b0000, 1'b0),
              mk_resp(1'b1, 5'd31, 32'hFFFF_8001, 1'b0, 1'b0, 32'h0, 1'b1));
        do_tx(1'b0, 3'b100, 32'h0000_1003, 32'h0, 5'd1, 2, 32'h80FF_FFFF, 1'b0, 1'b1,
              mk_bus(32'h0000_1000, 32'h0, 4'b0000, 1'b0),
              mk_resp(1'b1, 5'd1, 32'h0000_0080, 1'b0, 1'b0, 32'h0, 1'b1));
        do_tx(1'b1, 3'b000, 32'h0000_1001, 32'h0000_00AB, 5'd0, 1, 32'h0, 1'b0, 1'b1,
              mk_bus(32'h0000_1000, 32'hABAB_ABAB, 4'b0010, 1'b1),
              mk_resp(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1));
        do_tx(1'b0, 3'b011, 32'h0000_6000, 32'h0, 5'd3, 1, 32'h0, 1'b0, 1'b0,
              mk_bus(32'h0, 32'h0, 4'b0000, 1'b0),
              mk_resp(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h0000_6000, 1'b0));
        do_tx(1'b1, 3'b100, 32'h0000_6004, 32'h0, 5'd0, 1, 32'h0, 1'b0, 1'b0,
              mk_bus(32'h0, 32'h0, 4'b0000, 1'b0),
              mk_resp(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h0000_6004, 1'b0));
        do_tx(1'b0, 3'b001, 32'h0000_1001, 32'h0, 5'd3, 1, 32'h0, 1'b0, 1'b0,
              mk_bus(32'h0, 32'h0, 4'b0000, 1'b0),
              mk_resp(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h0000_1001, 1'b0));
        do_tx(1'b0, 3'b010, 32'h0000_7000, 32'h0, 5'd0, 1, 32'hDEAD_BEEF, 1'b0, 1'b1,
              mk_bus(32'h0000_7000, 32'h0, 4'b0000, 1'b0),
              mk_resp(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1));
        do_tx(1'b0, 3'b010, 32'h0000_7004, 32'h0, 5'd3, 2, 32'hCAFE_F00D, 1'b0, 1'b1,
              mk_bus(32'h0000_7004, 32'h0, 4'b0000, 1'b0),
              mk_resp(1'b1, 5'd3, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, 1'b1));

        // Reset pulsed in WAIT; the responder's late mem_ready lands in IDLE.
        r_delay = 6; r_rdata = 32'h1111_2222; r_err = 1'b0;
        exp_bus.push_back(mk_bus(32'h0000_5000, 32'h0, 4'b0000, 1'b0));
        @(posedge clk);
        #1;
        ls_is_store = 1'b0; ls_funct3 = 3'b010; ls_addr = 32'h0000_5000; ls_rd = 5'd9; ls_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_seq_req", {31'h0, mem_req}, 32'h1);
        @(negedge clk);
        chk("rst_seq_wait_addr", mem_addr, 32'h0000_5000);
        rst_n = 1'b0;
        ls_valid = 1'b0;
        #1;
        chk("rst_mid_wb_data", wb_data, 32'h0);
        chk("rst_mid_wb_rd", {27'h0, wb_rd}, 32'h0);
        chk("rst_mid_mem_addr", mem_addr, 32'h0);
        chk("rst_mid_exc_addr", exc_addr, 32'h0);
        chk("rst_mid_misc", {22'h0, mem_wstrb, wb_valid, misalign_exc, fault_exc, mem_req, mem_wr, ls_stall}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        r0 = req_count;
        wv = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (wb_valid === 1'b1) wv = 1'b1;
        end
        chk("rst_no_reissue", req_count - r0, 32'h0);
        chk("rst_no_wb_valid", {31'h0, wv}, 32'h0);
        chk("rst_after_wb_data", wb_data, 32'h0);

        do_tx(1'b0, 3'b010, 32'h0000_7004, 32'h0, 5'd3, 1, 32'h0BAD_CAFE, 1'b0, 1'b1,
              mk_bus(32'h0000_7004, 32'h0, 4'b0000, 1'b0),
              mk_resp(1'b1, 5'd3, 32'h0BAD_CAFE, 1'b0, 1'b0, 32'h0, 1'b1));

        chk("bus_queue_empty", exp_bus.size(), 32'h0);
        chk("resp_queue_empty", exp_resp.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
